// File: rtl/mem_arb_defs.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encoding, requester port IDs and the default wait-for-ready limit.
package mem_arb_defs;

  // Arbiter FSM states. The encoding is visible on the state_dbg output of
  // mem_arbiter, so it is pinned explicitly here.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } arb_state_t;

  // Requester IDs, also used as the last-grant encoding.
  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  // Default number of cycles to wait for m_ready before aborting.
  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between the instruction and data requesters.
// Purely combinational; the last-grant register lives in the parent.
module rr_arb2
  import mem_arb_defs::*;
(
  input  logic req_inst,
  input  logic req_data,
  input  logic last_grant,
  output logic winner
);

  // On a tie, the requester that was not served last wins; otherwise the
  // single active requester wins. With no request the output is don't-care
  // and defaults to INST.
  always_comb begin
    winner = PORT_INST;
    if (req_inst && req_data) begin
      winner = ~last_grant;
    end else if (req_data) begin
      winner = PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between an instruction-fetch requester and
// a data requester. One transaction at a time: IDLE -> ISSUE -> DONE -> IDLE.
//
// Handshakes:
//   Requester side: i_req/d_req are levels sampled only in IDLE. The winner's
//   addr/we/wdata are captured on the grant edge, so the requester may change
//   or drop them afterwards. Completion is a one-cycle *_done pulse with the
//   read data already valid on *_rdata in the same cycle.
//   Memory side: m_ce high means a request is presented; m_addr, m_we and
//   m_wdata stay stable while m_ce is high. The transfer completes on the
//   first rising edge where m_ce && m_ready, with m_rdata sampled at that
//   edge. If m_ready has not been seen after TIMEOUT ISSUE cycles, the
//   transaction is aborted: done pulses with rdata = 0 and err pulses with it.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  // memory port
  output logic        m_ce,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  // status
  output logic        busy,
  output logic        err,
  output logic [1:0]  state_dbg
);

  // Wait counter just wide enough to hold TIMEOUT.
  localparam int WCW = $clog2(TIMEOUT + 1);
  // Value of the counter during the last permitted ISSUE cycle.
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  arb_state_t     state;
  arb_state_t     state_nxt;
  logic           last_grant;
  logic           grant;
  logic           winner;
  logic           any_req;
  logic           ready_hit;
  logic           timeout_hit;
  logic [WCW-1:0] wait_cnt;

  assign any_req   = i_req | d_req;
  assign ready_hit = (state == S_ISSUE) && m_ready;
  // m_ready has priority: a ready arriving in the last permitted cycle
  // completes normally instead of timing out.
  assign timeout_hit = (state == S_ISSUE) && !m_ready && (wait_cnt == WAIT_LAST);

  rr_arb2 u_rr_arb2 (
    .req_inst   (i_req),
    .req_data   (d_req),
    .last_grant (last_grant),
    .winner     (winner)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ready_hit || timeout_hit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: grant capture, memory request, wait counting and completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= PORT_INST;
      grant      <= PORT_INST;
      wait_cnt   <= '0;
      m_ce       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      err        <= 1'b0;
    end else begin
      // done and err are single-cycle pulses by default
      i_done <= 1'b0;
      d_done <= 1'b0;
      err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant      <= winner;
            last_grant <= winner;
            wait_cnt   <= '0;
            m_ce       <= 1'b1;
            if (winner == PORT_DATA) begin
              m_addr  <= d_addr;
              m_we    <= d_we;
              m_wdata <= d_wdata;
            end else begin
              // instruction fetches are always reads
              m_addr  <= i_addr;
              m_we    <= 1'b0;
              m_wdata <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (ready_hit) begin
            m_ce <= 1'b0;
            if (grant == PORT_DATA) begin
              // writes also return whatever memory drives on m_rdata
              d_rdata <= m_rdata;
              d_done  <= 1'b1;
            end else begin
              i_rdata <= m_rdata;
              i_done  <= 1'b1;
            end
          end else if (timeout_hit) begin
            m_ce <= 1'b0;
            err  <= 1'b1;
            if (grant == PORT_DATA) begin
              d_rdata <= '0;
              d_done  <= 1'b1;
            end else begin
              i_rdata <= '0;
              i_done  <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: begin
          // S_DONE: the done/err pulse is on the outputs this cycle
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule
